addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_pkg.sv | 8 +
 rtl/cla15_core.sv | 46 ++++
 rtl/addsub_seq.sv | 95 +++++++++
 tb/tb_addsub_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and types for the sequential add/subtract unit.
package addsub_pkg;
  localparam int   WIDTH_DEF = 15;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/cla15_core.sv
// Combinational two's-complement add/sub built as a parallel-prefix
// (Kogge-Stone) carry-lookahead adder.
module cla15_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] bx, p, gk, pk, gn, pn;
  logic [WIDTH:0]   c;

  always_comb begin
    bx = b_i ^ {WIDTH{op_i}};
    p  = a_i ^ bx;
    gk = a_i & bx;
    // Fold the carry-in into bit 0 so prefix G[i:0] is directly carry i+1.
    gk[0] = gk[0] | (p[0] & op_i);
    pk = p;
    gn = gk;
    pn = pk;
    for (int lv = 0; lv < LEVELS; lv++) begin
      gn = gk;
      pn = pk;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << lv)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (1 << lv)]);
          pn[i] = pk[i] & pk[i - (1 << lv)];
        end
      end
      gk = gn;
      pk = pn;
    end
    c      = {gk, op_i};
    s_o    = p ^ c[WIDTH-1:0];
    cout_o = c[WIDTH];
    cmsb_o = c[WIDTH-1];
  end
endmodule

// File: rtl/addsub_seq.sv
// Handshaked add/subtract unit: IDLE accepts, EXEC computes, RESP holds
// the registered result until the consumer takes it.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic             op_q, carry_q, ovf_q, sticky_q;
  logic [WIDTH-1:0] s;
  logic             cout, cmsb, ovf_n, accept, exec;

  cla15_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .s_o    (s),
    .cout_o (cout),
    .cmsb_o (cmsb)
  );

  assign ovf_n  = cmsb ^ cout;
  assign accept = in_valid && in_ready;
  assign exec   = (state_q == EXEC);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= acc_sel ? acc_q : a_in;
        b_q  <= b_in;
        op_q <= op;
      end
      if (exec) begin
        result_q <= s;
        carry_q  <= cout;
        ovf_q    <= ovf_n;
        acc_q    <= s;
      end
      // A fresh overflow beats a simultaneous clear.
      if (exec && ovf_n)   sticky_q <= 1'b1;
      else if (clr_sticky) sticky_q <= 1'b0;
    end
  end

  assign result     = result_q;
  assign carry      = carry_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed scoreboard bench for addsub_seq (WIDTH = 15).
module tb_addsub_seq;
  localparam int W = 15;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         st;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, in_valid, op, acc_sel, out_ready, clr_sticky;
  logic [W-1:0] a_in, b_in;
  logic         in_ready, out_valid, carry, ovf, ovf_sticky;
  logic [W-1:0] result;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [W-1:0] acc_m = '0;
  logic         sticky_m = 1'b0;

  addsub_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .acc_sel    (acc_sel),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: full-width sum for carry, lower bits for MSB carry-in.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic o, input logic clr, input logic st_in);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] low;
    bx   = b ^ {W{o}};
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, o};
    low  = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, o};
    e.r  = full[W-1:0];
    e.c  = full[W];
    e.o  = low[W-1] ^ full[W];
    e.st = e.o ? 1'b1 : (clr ? 1'b0 : st_in);
    return e;
  endfunction

  // One full transaction starting at posedge+1 in IDLE; ends back in IDLE.
  task automatic do_op(input string tag, input logic sel, input logic o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input logic clr);
    exp_t e, got;
    logic [W-1:0] held;
    e = model(sel ? acc_m : a, b, o, clr, sticky_m);
    sb.push_back(e);
    acc_m    = e.r;
    sticky_m = e.st;
    in_valid = 1'b1; acc_sel = sel; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    op = 1'($urandom); acc_sel = 1'($urandom); clr_sticky = clr;
    check({tag, "_exec_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_exec_iready"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check({tag, "_latency_ovalid"}, 32'(out_valid), 32'd1);
    held = result;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a_in = W'($urandom); b_in = W'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_ovalid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_iready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_result"}, 32'(result), 32'(held));
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(got.r));
    check({tag, "_carry"}, 32'(carry), 32'(got.c));
    check({tag, "_ovf"}, 32'(ovf), 32'(got.o));
    check({tag, "_sticky"}, 32'(ovf_sticky), 32'(got.st));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_done_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_iready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 1'b0; acc_sel = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Idle in_valid=0 with garbage on the inputs must not start anything.
    a_in = 15'h1234; b_in = 15'h0F0F;
    @(posedge clk); #1;
    check("idle_ignore_ovalid", 32'(out_valid), 32'd0);
    check("idle_ignore_iready", 32'(in_ready), 32'd1);

    do_op("add16_2", 1'b0, 1'b0, 15'd16, 15'd2, 0, 1'b0);
    check("add16_2_const", 32'(result), 32'd18);
    do_op("sub1000", 1'b0, 1'b1, 15'd1000, 15'd1000, 0, 1'b0);
    do_op("subneg1000", 1'b0, 1'b1, 15'(-1000), 15'(-1000), 0, 1'b0);
    do_op("ovf_pos", 1'b0, 1'b0, 15'd9000, 15'd8000, 0, 1'b0);
    check("ovf_pos_const", 32'(result), 32'h4268);
    do_op("ovf_neg", 1'b0, 1'b1, 15'(-15000), 15'd3000, 0, 1'b0);
    check("ovf_neg_const", 32'(result), 32'd14768);
    do_op("clr_only", 1'b0, 1'b0, 15'd1, 15'd1, 0, 1'b1);

    do_op("acc_seed", 1'b0, 1'b0, 15'd17, 15'(-3), 0, 1'b0);
    do_op("acc_sub4", 1'b1, 1'b1, 15'h5555, 15'd4, 0, 1'b0);
    check("acc_sub4_const", 32'(result), 32'd10);
    do_op("acc_addm12", 1'b1, 1'b0, 15'h2AAA, 15'(-12), 5, 1'b0);
    check("acc_addm12_const", 32'(result), 32'h7FFE);

    do_op("clr_vs_set", 1'b0, 1'b0, 15'd9000, 15'd8000, 0, 1'b1);
    check("clr_vs_set_const", 32'(ovf_sticky), 32'd1);
    do_op("min_neg_sub", 1'b0, 1'b1, 15'd0, 15'h4000, 2, 1'b0);

    // Reset mid-EXEC with a pending overflow op and a clear request.
    in_valid = 1'b1; acc_sel = 1'b0; op = 1'b0; a_in = 15'd9000; b_in = 15'd8000;
    @(posedge clk); #1;
    in_valid = 1'b1; reset = 1'b1; clr_sticky = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0;
    acc_m = '0; sticky_m = 1'b0;
    check("rstexec_ovalid", 32'(out_valid), 32'd0);
    check("rstexec_iready", 32'(in_ready), 32'd1);
    check("rstexec_result", 32'(result), 32'd0);
    check("rstexec_sticky", 32'(ovf_sticky), 32'd0);
    do_op("rstexec_acc", 1'b1, 1'b0, 15'h7777, 15'd0, 0, 1'b0);
    check("rstexec_acc_const", 32'(result), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
